// File: rtl/bf8b_sequencer_if.sv
// bf8b_sequencer_if: shared memory port plus the execute-unit handshake.
interface bf8b_sequencer_if;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       exec_en;
  logic [7:0] exec_inst;
  logic       exec_ready;
  logic       exec_jump;
  logic [7:0] exec_target;
  logic [7:0] exec_addr;
  logic       exec_we;
  logic [7:0] exec_wdata;
  modport master (
    output mem_addr, mem_we, mem_wdata, exec_en, exec_inst,
    input  mem_rdata, exec_ready, exec_jump, exec_target, exec_addr, exec_we, exec_wdata
  );
  modport slave (
    input  mem_addr, mem_we, mem_wdata, exec_en, exec_inst,
    output mem_rdata, exec_ready, exec_jump, exec_target, exec_addr, exec_we, exec_wdata
  );
endinterface

// File: rtl/bf8b_sequencer.sv
// bf8b_sequencer: fetch/execute controller owning the PC and the shared memory port.
module bf8b_sequencer #(
  parameter logic [7:0]  RESET_PC     = 8'h00,
  parameter logic [7:0]  HALT_OPCODE  = 8'hFF,
  parameter int unsigned EXEC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             halt_req_i,
  output logic [7:0]       pc_o,
  output logic             running_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [15:0]      retired_o,
  bf8b_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d, inst_q, inst_d, cnt_q, cnt_d;
  logic [15:0] ret_q, ret_d;
  logic        en_q, en_d, fault_q, fault_d;
  logic        in_exec, timeout, is_halt;
  assign in_exec = state_q == S_EXEC;
  assign timeout = cnt_q + 8'd1 == 8'(EXEC_TIMEOUT);
  assign is_halt = bus.mem_rdata == HALT_OPCODE;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    en_d    = en_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE:   state_d = start_i ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH: begin
        inst_d  = bus.mem_rdata;
        state_d = is_halt ? S_HALTED : S_EXEC;
        en_d    = !is_halt;
        cnt_d   = 8'd0;
      end
      S_EXEC: begin
        // completion beats a timeout that lands on the same cycle
        if (bus.exec_ready) begin
          pc_d    = bus.exec_jump ? bus.exec_target : pc_q + 8'd1;
          ret_d   = ret_q + 16'd1;
          en_d    = 1'b0;
          state_d = halt_req_i ? S_HALTED : S_FETCH;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = timeout ? S_FAULT : S_EXEC;
          fault_d = fault_q | timeout;
          en_d    = !timeout;
        end
      end
      S_HALTED: state_d = (start_i && !halt_req_i) ? S_FETCH : S_HALTED;
      default:  state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 8'd0;
      cnt_q   <= 8'd0;
      ret_q   <= 16'd0;
      en_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      en_q    <= en_d;
      fault_q <= fault_d;
    end
  end
  assign bus.mem_addr  = in_exec ? bus.exec_addr : pc_q;
  assign bus.mem_we    = in_exec && bus.exec_we;
  assign bus.mem_wdata = in_exec ? bus.exec_wdata : 8'h00;
  assign bus.exec_en   = en_q;
  assign bus.exec_inst = inst_q;
  assign pc_o      = pc_q;
  assign running_o = state_q inside {S_FETCH, S_LATCH, S_EXEC};
  assign halted_o  = state_q == S_HALTED;
  assign fault_o   = fault_q;
  assign retired_o = ret_q;
endmodule

// File: tb/tb_bf8b_sequencer.sv
// tb_bf8b_sequencer: directed program runs checked against a cycle model of the sequencer.
module tb_bf8b_sequencer;
  localparam int TMO = 4;
  localparam int M_IDLE = 0, M_FETCH = 1, M_LATCH = 2, M_EXEC = 3, M_HALT = 4, M_FAULT = 5;
  logic clk, rst_n, start, halt_req;
  logic [7:0] pc;
  logic running, halted, fault;
  logic [15:0] retired;
  logic [7:0] mem [256];
  logic auto_rdy, jump_en;
  logic [7:0] jump_pc;
  logic wr_seen;
  logic [7:0] wr_addr, wr_data;
  int n_chk, n_err, cycles;
  logic [7:0] seen [$];
  int m_st, m_wait;
  logic [7:0] m_pc, m_inst;
  logic [15:0] m_ret;
  logic m_fault, m_en, mvalid;
  bf8b_sequencer_if bus ();
  bf8b_sequencer #(.EXEC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .halt_req_i(halt_req),
    .pc_o(pc), .running_o(running), .halted_o(halted), .fault_o(fault),
    .retired_o(retired), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) begin
      wr_seen <= 1'b1;
      wr_addr <= bus.mem_addr;
      wr_data <= bus.mem_wdata;
    end
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_pc <= 8'h00; m_inst <= 8'h00; m_ret <= 16'd0;
      m_fault <= 1'b0; m_en <= 1'b0; m_wait <= 0; mvalid <= 1'b1;
    end else if (m_st == M_IDLE) begin
      if (start) m_st <= M_FETCH;
    end else if (m_st == M_HALT) begin
      if (start && !halt_req) m_st <= M_FETCH;
    end else if (m_st == M_FETCH) begin
      m_st <= M_LATCH;
    end else if (m_st == M_LATCH) begin
      m_inst <= mem[m_pc];
      if (mem[m_pc] == 8'hFF) m_st <= M_HALT;
      else begin m_st <= M_EXEC; m_en <= 1'b1; m_wait <= 0; end
    end else if (m_st == M_EXEC) begin
      if (bus.exec_ready) begin
        m_pc  <= bus.exec_jump ? bus.exec_target : m_pc + 8'd1;
        m_ret <= m_ret + 16'd1;
        m_en  <= 1'b0;
        m_st  <= halt_req ? M_HALT : M_FETCH;
      end else if (m_wait + 1 == TMO) begin
        m_st <= M_FAULT; m_fault <= 1'b1; m_en <= 1'b0;
      end else m_wait <= m_wait + 1;
    end
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (mvalid) begin
    chk("pc", 16'(pc), 16'(m_pc));
    chk("retired", retired, m_ret);
    chk("fault", 16'(fault), 16'(m_fault));
    chk("halted", 16'(halted), 16'(m_st == M_HALT));
    chk("running", 16'(running), 16'(m_st inside {M_FETCH, M_LATCH, M_EXEC}));
    chk("exec_en", 16'(bus.exec_en), 16'(m_en));
    chk("exec_inst", 16'(bus.exec_inst), 16'(m_inst));
    chk("mem_addr", 16'(bus.mem_addr), 16'(m_st == M_EXEC ? bus.exec_addr : m_pc));
    chk("mem_we", 16'(bus.mem_we), 16'(m_st == M_EXEC && bus.exec_we));
    if (bus.mem_we) chk("mem_wdata", 16'(bus.mem_wdata), 16'(bus.exec_wdata));
  end
  task automatic upd();
    bus.exec_ready = auto_rdy && bus.exec_en;
    bus.exec_jump  = jump_en && pc == jump_pc;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    upd();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_halt();
    for (int i = 0; i < 60 && !halted; i++) step();
    chk("halt_reached", 16'(halted), 16'd1);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; auto_rdy = 1'b1; jump_en = 1'b0;
    jump_pc = 8'h00; wr_seen = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    n_chk = 0; n_err = 0; mvalid = 1'b0;
    bus.exec_ready = 1'b0; bus.exec_jump = 1'b0; bus.exec_target = 8'h00;
    bus.exec_addr = 8'h00; bus.exec_we = 1'b0; bus.exec_wdata = 8'h00;
    step(); step();
    chk("rst_pc", 16'(pc), 16'h0);
    chk("rst_mem_addr", 16'(bus.mem_addr), 16'h0);
    chk("rst_exec_en", 16'(bus.exec_en), 16'h0);
    chk("rst_retired", retired, 16'h0);
    rst_n = 1'b1;
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'hFF;
    pulse_start();
    cycles = 1;
    while (!halted && cycles < 40) begin
      step();
      cycles++;
      if (bus.exec_en) seen.push_back(bus.exec_inst);
    end
    chk("seq_cycles", 16'(cycles), 16'd9);
    chk("seq_count", 16'(seen.size()), 16'd2);
    if (seen.size() == 2) begin
      chk("seq_inst0", 16'(seen[0]), 16'h41);
      chk("seq_inst1", 16'(seen[1]), 16'h42);
    end
    chk("seq_halted", 16'(halted), 16'd1);
    chk("seq_pc", 16'(pc), 16'h02);
    chk("seq_retired", retired, 16'd2);
    mem[2] = 8'h01; mem[3] = 8'h02; mem[4] = 8'h03; mem[5] = 8'h10; mem[8'h20] = 8'hFF;
    jump_en = 1'b1; jump_pc = 8'h05; bus.exec_target = 8'h20;
    pulse_start();
    wait_halt();
    chk("jump_pc", 16'(pc), 16'h20);
    chk("jump_retired", retired, 16'd6);
    mem[8'h20] = 8'h11; mem[8'hFF] = 8'h12; mem[0] = 8'hFF;
    jump_pc = 8'h20; bus.exec_target = 8'hFF;
    pulse_start();
    wait_halt();
    chk("wrap_pc", 16'(pc), 16'h00);
    chk("wrap_retired", retired, 16'd8);
    chk("wrap_inst", 16'(bus.exec_inst), 16'hFF);
    jump_en = 1'b0; mem[0] = 8'h33; mem[1] = 8'hFF;
    auto_rdy = 1'b0; bus.exec_addr = 8'h80; bus.exec_we = 1'b1; bus.exec_wdata = 8'h5A;
    pulse_start();
    chk("arb_fetch_we", 16'(bus.mem_we), 16'd0);
    chk("arb_fetch_addr", 16'(bus.mem_addr), 16'h00);
    step();
    chk("arb_latch_we", 16'(bus.mem_we), 16'd0);
    chk("arb_latch_addr", 16'(bus.mem_addr), 16'h00);
    step();
    chk("arb_exec_addr", 16'(bus.mem_addr), 16'h80);
    chk("arb_exec_we", 16'(bus.mem_we), 16'd1);
    chk("arb_exec_wdata", 16'(bus.mem_wdata), 16'h5A);
    auto_rdy = 1'b1;
    upd();
    step();
    chk("arb_post_we", 16'(bus.mem_we), 16'd0);
    chk("arb_post_addr", 16'(bus.mem_addr), 16'h01);
    bus.exec_we = 1'b0; bus.exec_addr = 8'h00; bus.exec_wdata = 8'h00;
    wait_halt();
    chk("arb_write_seen", 16'(wr_seen), 16'd1);
    chk("arb_write_addr", 16'(wr_addr), 16'h80);
    chk("arb_write_data", 16'(wr_data), 16'h5A);
    mem[1] = 8'h44; auto_rdy = 1'b0;
    pulse_start();
    cycles = 1;
    while (!fault && cycles < 30) begin step(); cycles++; end
    chk("tmo_cycles", 16'(cycles), 16'd7);
    chk("tmo_fault", 16'(fault), 16'd1);
    chk("tmo_exec_en", 16'(bus.exec_en), 16'd0);
    chk("tmo_pc", 16'(pc), 16'h01);
    pulse_start();
    step();
    chk("tmo_start_ignored", 16'(running), 16'd0);
    chk("tmo_sticky", 16'(fault), 16'd1);
    rst_n = 1'b0;
    step();
    chk("tmo_rst_fault", 16'(fault), 16'd0);
    chk("tmo_rst_pc", 16'(pc), 16'h00);
    rst_n = 1'b1;
    mem[0] = 8'h51; mem[1] = 8'h52; mem[2] = 8'hFF; auto_rdy = 1'b1;
    pulse_start();
    step();
    halt_req = 1'b1;
    step();
    step();
    chk("hreq_halted", 16'(halted), 16'd1);
    chk("hreq_pc", 16'(pc), 16'h01);
    chk("hreq_retired", retired, 16'd1);
    pulse_start();
    chk("hreq_start_blocked", 16'(halted), 16'd1);
    halt_req = 1'b0;
    pulse_start();
    chk("resume_running", 16'(running), 16'd1);
    chk("resume_addr", 16'(bus.mem_addr), 16'h01);
    wait_halt();
    chk("resume_pc", 16'(pc), 16'h02);
    chk("resume_retired", retired, 16'd2);
    mem[2] = 8'h60; auto_rdy = 1'b0;
    pulse_start();
    step();
    step();
    chk("mid_exec_en", 16'(bus.exec_en), 16'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_exec_en", 16'(bus.exec_en), 16'd0);
    chk("mid_rst_running", 16'(running), 16'd0);
    chk("mid_rst_pc", 16'(pc), 16'h00);
    rst_n = 1'b1;
    step();
    chk("mid_rst_idle", 16'(running), 16'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
